// File: rtl/ec_fp_mult_arb.sv
// Round-robin front end for one shared pipelined Fp multiplier: tags each request with its channel,
// then strips the tag from each returning product and steers it to that channel's output register.
module ec_fp_mult_arb #(
  parameter int  NUM_IN   = 4,
  parameter int  DAT_BITS = 381,
  parameter int  CTL_BITS = 16,
  localparam int TAG_BITS = $clog2(NUM_IN)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  // Ready lines carry their own direction prefix plus the name of the stream they belong to.
  input  logic [NUM_IN-1:0]                    i_req_val,
  input  logic [NUM_IN-1:0][2*DAT_BITS-1:0]    i_req_dat,
  input  logic [NUM_IN-1:0][CTL_BITS-1:0]      i_req_ctl,
  output logic [NUM_IN-1:0]                    o_i_req_rdy,
  output logic                                 o_mul_val,
  output logic [2*DAT_BITS-1:0]                o_mul_dat,
  output logic [CTL_BITS-1:0]                  o_mul_ctl,
  output logic                                 o_mul_sop,
  output logic                                 o_mul_eop,
  output logic                                 o_mul_mod,
  output logic                                 o_mul_err,
  input  logic                                 i_o_mul_rdy,
  input  logic                                 i_mul_val,
  input  logic [DAT_BITS-1:0]                  i_mul_dat,
  input  logic [CTL_BITS-1:0]                  i_mul_ctl,
  input  logic                                 i_mul_err,
  output logic                                 o_i_mul_rdy,
  output logic [NUM_IN-1:0]                    o_res_val,
  output logic [NUM_IN-1:0][DAT_BITS-1:0]      o_res_dat,
  output logic [NUM_IN-1:0][CTL_BITS-1:0]      o_res_ctl,
  output logic [NUM_IN-1:0]                    o_res_err,
  output logic [NUM_IN-1:0]                    o_res_sop,
  output logic [NUM_IN-1:0]                    o_res_eop,
  output logic [NUM_IN-1:0]                    o_res_mod,
  input  logic [NUM_IN-1:0]                    i_o_res_rdy,
  output logic                                 o_tag_err
);

  logic                               r_mul_val;
  logic [2*DAT_BITS-1:0]              r_mul_dat;
  logic [CTL_BITS-1:0]                r_mul_ctl;
  logic [TAG_BITS-1:0]                r_rr_ptr;
  logic [NUM_IN-1:0]                  r_res_val;
  logic [NUM_IN-1:0][DAT_BITS-1:0]    r_res_dat;
  logic [NUM_IN-1:0][CTL_BITS-1:0]    r_res_ctl;
  logic [NUM_IN-1:0]                  r_res_err;
  logic                               r_tag_err;

  logic [TAG_BITS-1:0]                w_gnt;
  logic                               w_gnt_vld;
  logic                               w_load;
  logic                               w_acc;
  logic [CTL_BITS-1:0]                w_req_ctl;
  logic [TAG_BITS-1:0]                w_tag;
  logic                               w_tag_ok;
  logic                               w_res_free;
  logic                               w_res_acc;
  logic [CTL_BITS-1:0]                w_res_ctl;

  function automatic logic [TAG_BITS-1:0] f_wrap(input logic [TAG_BITS-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IN) s = s - NUM_IN;
    return TAG_BITS'(s);
  endfunction

  // Scan from the far end so the channel closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int i = NUM_IN-1; i >= 0; i--) begin
      if (i_req_val[f_wrap(r_rr_ptr, i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = f_wrap(r_rr_ptr, i);
      end
    end
    w_req_ctl = i_req_ctl[w_gnt];
    w_req_ctl[CTL_BITS-1 -: TAG_BITS] = w_gnt;
  end

  assign w_load = !r_mul_val || i_o_mul_rdy;
  assign w_acc  = i_rst && w_load && w_gnt_vld;

  always_comb begin
    o_i_req_rdy = '0;
    for (int k = 0; k < NUM_IN; k++)
      o_i_req_rdy[k] = w_acc && (w_gnt == TAG_BITS'(k));
  end

  // Out-of-range tags match no channel, so they leave w_res_free at 1 and get drained.
  always_comb begin
    w_tag      = i_mul_ctl[CTL_BITS-1 -: TAG_BITS];
    w_tag_ok   = int'(w_tag) < NUM_IN;
    w_res_free = 1'b1;
    for (int k = 0; k < NUM_IN; k++)
      if (w_tag == TAG_BITS'(k)) w_res_free = !r_res_val[k] || i_o_res_rdy[k];
    w_res_ctl = i_mul_ctl;
    w_res_ctl[CTL_BITS-1 -: TAG_BITS] = '0;
  end

  assign o_i_mul_rdy = i_rst && w_res_free;
  assign w_res_acc   = i_mul_val && o_i_mul_rdy;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mul_val <= 1'b0;
      r_mul_dat <= '0;
      r_mul_ctl <= '0;
      r_rr_ptr  <= '0;
      r_res_val <= '0;
      r_res_dat <= '0;
      r_res_ctl <= '0;
      r_res_err <= '0;
      r_tag_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_mul_val <= w_gnt_vld;
        if (w_gnt_vld) begin
          r_mul_dat <= i_req_dat[w_gnt];
          r_mul_ctl <= w_req_ctl;
          r_rr_ptr  <= (int'(w_gnt) == NUM_IN-1) ? '0 : w_gnt + 1'b1;
        end
      end
      for (int k = 0; k < NUM_IN; k++) begin
        if (w_res_acc && (w_tag == TAG_BITS'(k))) begin
          r_res_val[k] <= 1'b1;
          r_res_dat[k] <= i_mul_dat;
          r_res_ctl[k] <= w_res_ctl;
          r_res_err[k] <= i_mul_err;
        end else if (i_o_res_rdy[k]) begin
          r_res_val[k] <= 1'b0;
        end
      end
      r_tag_err <= w_res_acc && !w_tag_ok;
    end
  end

  assign o_mul_val = r_mul_val;
  assign o_mul_dat = r_mul_dat;
  assign o_mul_ctl = r_mul_ctl;
  assign o_mul_sop = 1'b1;
  assign o_mul_eop = 1'b1;
  assign o_mul_mod = 1'b0;
  assign o_mul_err = 1'b0;
  assign o_res_val = r_res_val;
  assign o_res_dat = r_res_dat;
  assign o_res_ctl = r_res_ctl;
  assign o_res_err = r_res_err;
  assign o_res_sop = '1;
  assign o_res_eop = '1;
  assign o_res_mod = '0;
  assign o_tag_err = r_tag_err;

endmodule

// File: tb/tb_ec_fp_mult_arb.sv
// Directed bench for ec_fp_mult_arb: a 4-channel instance for most scenarios, a 3-channel one for tag overflow.
module tb_ec_fp_mult_arb;
  localparam int N  = 4;
  localparam int D  = 381;
  localparam int C  = 16;
  localparam int N3 = 3;
  localparam int D3 = 16;
  localparam int NP = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [N-1:0]            req_val, req_rdy;
  logic [N-1:0][2*D-1:0]   req_dat;
  logic [N-1:0][C-1:0]     req_ctl;
  logic                    mul_o_val, mul_o_sop, mul_o_eop, mul_o_mod, mul_o_err, mul_o_rdy;
  logic [2*D-1:0]          mul_o_dat;
  logic [C-1:0]            mul_o_ctl;
  logic                    mul_i_val, mul_i_err, mul_i_rdy;
  logic [D-1:0]            mul_i_dat;
  logic [C-1:0]            mul_i_ctl;
  logic [N-1:0]            res_val, res_err, res_sop, res_eop, res_mod, res_rdy;
  logic [N-1:0][D-1:0]     res_dat;
  logic [N-1:0][C-1:0]     res_ctl;
  logic                    tag_err;

  logic [N3-1:0]           x_req_val, x_req_rdy;
  logic [N3-1:0][2*D3-1:0] x_req_dat;
  logic [N3-1:0][C-1:0]    x_req_ctl;
  logic                    x_mul_o_val, x_mul_o_sop, x_mul_o_eop, x_mul_o_mod, x_mul_o_err, x_mul_o_rdy;
  logic [2*D3-1:0]         x_mul_o_dat;
  logic [C-1:0]            x_mul_o_ctl;
  logic                    x_mul_i_val, x_mul_i_err, x_mul_i_rdy;
  logic [D3-1:0]           x_mul_i_dat;
  logic [C-1:0]            x_mul_i_ctl;
  logic [N3-1:0]           x_res_val, x_res_err, x_res_sop, x_res_eop, x_res_mod, x_res_rdy;
  logic [N3-1:0][D3-1:0]   x_res_dat;
  logic [N3-1:0][C-1:0]    x_res_ctl;
  logic                    x_tag_err;

  int n_checks = 0;
  int n_fail   = 0;

  ec_fp_mult_arb #(.NUM_IN(N), .DAT_BITS(D), .CTL_BITS(C)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_val(req_val), .i_req_dat(req_dat), .i_req_ctl(req_ctl), .o_i_req_rdy(req_rdy),
    .o_mul_val(mul_o_val), .o_mul_dat(mul_o_dat), .o_mul_ctl(mul_o_ctl), .o_mul_sop(mul_o_sop),
    .o_mul_eop(mul_o_eop), .o_mul_mod(mul_o_mod), .o_mul_err(mul_o_err), .i_o_mul_rdy(mul_o_rdy),
    .i_mul_val(mul_i_val), .i_mul_dat(mul_i_dat), .i_mul_ctl(mul_i_ctl), .i_mul_err(mul_i_err),
    .o_i_mul_rdy(mul_i_rdy),
    .o_res_val(res_val), .o_res_dat(res_dat), .o_res_ctl(res_ctl), .o_res_err(res_err),
    .o_res_sop(res_sop), .o_res_eop(res_eop), .o_res_mod(res_mod), .i_o_res_rdy(res_rdy),
    .o_tag_err(tag_err)
  );

  ec_fp_mult_arb #(.NUM_IN(N3), .DAT_BITS(D3), .CTL_BITS(C)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_req_val(x_req_val), .i_req_dat(x_req_dat), .i_req_ctl(x_req_ctl), .o_i_req_rdy(x_req_rdy),
    .o_mul_val(x_mul_o_val), .o_mul_dat(x_mul_o_dat), .o_mul_ctl(x_mul_o_ctl), .o_mul_sop(x_mul_o_sop),
    .o_mul_eop(x_mul_o_eop), .o_mul_mod(x_mul_o_mod), .o_mul_err(x_mul_o_err), .i_o_mul_rdy(x_mul_o_rdy),
    .i_mul_val(x_mul_i_val), .i_mul_dat(x_mul_i_dat), .i_mul_ctl(x_mul_i_ctl), .i_mul_err(x_mul_i_err),
    .o_i_mul_rdy(x_mul_i_rdy),
    .o_res_val(x_res_val), .o_res_dat(x_res_dat), .o_res_ctl(x_res_ctl), .o_res_err(x_res_err),
    .o_res_sop(x_res_sop), .o_res_eop(x_res_eop), .o_res_mod(x_res_mod), .i_o_res_rdy(x_res_rdy),
    .o_tag_err(x_tag_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_val = '0; req_dat = '0; req_ctl = '0; mul_o_rdy = 1'b1;
    mul_i_val = 1'b0; mul_i_dat = '0; mul_i_ctl = '0; mul_i_err = 1'b0; res_rdy = '1;
    x_req_val = '0; x_req_dat = '0; x_req_ctl = '0; x_mul_o_rdy = 1'b1;
    x_mul_i_val = 1'b0; x_mul_i_dat = '0; x_mul_i_ctl = '0; x_mul_i_err = 1'b0; x_res_rdy = '1;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [D-1:0] ea(input int k, input int j);
    return D'(k * 37 + j * 5 + 1);
  endfunction

  function automatic logic [D-1:0] eb(input int k, input int j);
    return D'(j * 11 + k + 2);
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b0; req_val = '1; mul_i_val = 1'b1; x_mul_i_val = 1'b1;
    repeat (3) tick();
    n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_req_rdy: got %b want 0000", req_rdy); end
    n_checks++; if (mul_i_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_mul_i_rdy: got %b want 0", mul_i_rdy); end
    n_checks++; if (x_mul_i_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_x_mul_i_rdy: got %b want 0", x_mul_i_rdy); end
    n_checks++; if (mul_o_val !== 1'b0) begin n_fail++; $display("FAIL reset_mul_o_val: got %b want 0", mul_o_val); end
    n_checks++; if (res_val !== 4'b0000) begin n_fail++; $display("FAIL reset_res_val: got %b want 0000", res_val); end
    n_checks++; if (tag_err !== 1'b0 || x_tag_err !== 1'b0) begin n_fail++; $display("FAIL reset_tag_err: got %b/%b want 0/0", tag_err, x_tag_err); end
    n_checks++; if (mul_o_ctl !== 16'h0000) begin n_fail++; $display("FAIL reset_mul_o_ctl: got %h want 0000", mul_o_ctl); end
    n_checks++; if (x_mul_o_val !== 1'b0 || x_res_val !== 3'b000) begin n_fail++; $display("FAIL reset_x_val: got %b/%b want 0/000", x_mul_o_val, x_res_val); end
    idle();
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [2*D-1:0] e;
    idle();
    e = {D'(5), D'(3)};
    req_val[2] = 1'b1; req_dat[2] = e; req_ctl[2] = 16'h00AB;
    #1;
    n_checks++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL single_req_rdy: got %b want 0100", req_rdy); end
    tick();
    req_val = '0;
    n_checks++; if (mul_o_val !== 1'b1) begin n_fail++; $display("FAIL single_mul_val: got %b want 1", mul_o_val); end
    n_checks++; if (mul_o_dat !== e) begin n_fail++; $display("FAIL single_mul_dat: got %h want %h", mul_o_dat, e); end
    n_checks++; if (mul_o_ctl !== 16'h80AB) begin n_fail++; $display("FAIL single_mul_ctl: got %h want 80ab", mul_o_ctl); end
    n_checks++; if ({mul_o_sop, mul_o_eop, mul_o_mod, mul_o_err} !== 4'b1100) begin n_fail++; $display("FAIL single_mul_flags: got %b want 1100", {mul_o_sop, mul_o_eop, mul_o_mod, mul_o_err}); end
    mul_i_val = 1'b1; mul_i_dat = D'(15); mul_i_ctl = 16'h80AB;
    #1;
    n_checks++; if (mul_i_rdy !== 1'b1) begin n_fail++; $display("FAIL single_mul_i_rdy: got %b want 1", mul_i_rdy); end
    tick();
    mul_i_val = 1'b0;
    n_checks++; if (res_val !== 4'b0100) begin n_fail++; $display("FAIL single_res_val: got %b want 0100", res_val); end
    n_checks++; if (res_dat[2] !== D'(15)) begin n_fail++; $display("FAIL single_res_dat: got %0d want 15", res_dat[2]); end
    n_checks++; if (res_ctl[2] !== 16'h00AB) begin n_fail++; $display("FAIL single_res_ctl: got %h want 00ab", res_ctl[2]); end
    n_checks++; if ({res_sop[2], res_eop[2], res_mod[2], res_err[2]} !== 4'b1100) begin n_fail++; $display("FAIL single_res_flags: got %b want 1100", {res_sop[2], res_eop[2], res_mod[2], res_err[2]}); end
    n_checks++; if (mul_o_val !== 1'b0) begin n_fail++; $display("FAIL single_mul_drain: got %b want 0", mul_o_val); end
    tick();
    n_checks++; if (res_val !== 4'b0000) begin n_fail++; $display("FAIL single_res_drain: got %b want 0000", res_val); end
  endtask

  task automatic test_fairness();
    logic [1:0] ex;
    idle();
    rst_pulse();
    req_val = '1;
    for (int k = 0; k < N; k++) req_ctl[k] = C'(k);
    for (int i = 0; i < 8; i++) begin
      ex = 2'(i % 4);
      #1;
      n_checks++; if (req_rdy !== 4'(1 << ex)) begin n_fail++; $display("FAIL fair_all_rdy[%0d]: got %b want %b", i, req_rdy, 4'(1 << ex)); end
      tick();
      n_checks++; if (mul_o_val !== 1'b1 || mul_o_ctl !== {ex, 14'(ex)}) begin n_fail++; $display("FAIL fair_all_ctl[%0d]: got val=%b ctl=%h want val=1 ctl=%h", i, mul_o_val, mul_o_ctl, {ex, 14'(ex)}); end
    end
    req_val = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      ex = (i % 2 == 0) ? 2'd1 : 2'd3;
      #1;
      n_checks++; if (req_rdy !== 4'(1 << ex)) begin n_fail++; $display("FAIL fair_odd_rdy[%0d]: got %b want %b", i, req_rdy, 4'(1 << ex)); end
      tick();
      n_checks++; if (mul_o_ctl !== {ex, 14'(ex)}) begin n_fail++; $display("FAIL fair_odd_ctl[%0d]: got %h want %h", i, mul_o_ctl, {ex, 14'(ex)}); end
    end
  endtask

  task automatic test_issue_backpressure();
    logic [2*D-1:0] e;
    idle();
    rst_pulse();
    req_val = '1;
    for (int k = 0; k < N; k++) begin
      req_dat[k] = {D'(k + 20), D'(k + 10)};
      req_ctl[k] = 16'h0100 + C'(k);
    end
    repeat (2) tick();
    mul_o_rdy = 1'b0;
    e = {D'(21), D'(11)};
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL ibp_req_rdy[%0d]: got %b want 0000", i, req_rdy); end
      n_checks++; if (mul_o_val !== 1'b1 || mul_o_dat !== e || mul_o_ctl !== 16'h4101) begin n_fail++; $display("FAIL ibp_hold[%0d]: got val=%b ctl=%h dat=%h want val=1 ctl=4101 dat=%h", i, mul_o_val, mul_o_ctl, mul_o_dat, e); end
      tick();
    end
    mul_o_rdy = 1'b1;
    #1;
    n_checks++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL ibp_resume_rdy: got %b want 0100", req_rdy); end
    tick();
    e = {D'(22), D'(12)};
    n_checks++; if (mul_o_ctl !== 16'h8102 || mul_o_dat !== e) begin n_fail++; $display("FAIL ibp_resume_beat: got ctl=%h dat=%h want ctl=8102 dat=%h", mul_o_ctl, mul_o_dat, e); end
    tick();
    n_checks++; if (mul_o_ctl !== 16'hC103) begin n_fail++; $display("FAIL ibp_next_beat: got ctl=%h want c103", mul_o_ctl); end
  endtask

  task automatic test_result_backpressure();
    idle();
    rst_pulse();
    res_rdy = 4'b1101;
    mul_i_val = 1'b1; mul_i_dat = D'(7); mul_i_ctl = 16'h4011;
    #1;
    n_checks++; if (mul_i_rdy !== 1'b1) begin n_fail++; $display("FAIL rbp_first_rdy: got %b want 1", mul_i_rdy); end
    tick();
    mul_i_dat = D'(8); mul_i_ctl = 16'h4012;
    n_checks++; if (res_val !== 4'b0010 || res_ctl[1] !== 16'h0011) begin n_fail++; $display("FAIL rbp_first_res: got val=%b ctl=%h want val=0010 ctl=0011", res_val, res_ctl[1]); end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (mul_i_rdy !== 1'b0) begin n_fail++; $display("FAIL rbp_stall_rdy[%0d]: got %b want 0", i, mul_i_rdy); end
      n_checks++; if (res_val[1] !== 1'b1 || res_dat[1] !== D'(7)) begin n_fail++; $display("FAIL rbp_hold[%0d]: got val=%b dat=%0d want val=1 dat=7", i, res_val[1], res_dat[1]); end
      tick();
    end
    res_rdy = '1;
    #1;
    n_checks++; if (mul_i_rdy !== 1'b1) begin n_fail++; $display("FAIL rbp_release_rdy: got %b want 1", mul_i_rdy); end
    tick();
    n_checks++; if (res_val !== 4'b0010 || res_dat[1] !== D'(8)) begin n_fail++; $display("FAIL rbp_passthru: got val=%b dat=%0d want val=0010 dat=8", res_val, res_dat[1]); end
    mul_i_dat = D'(9); mul_i_ctl = 16'h0022;
    #1;
    n_checks++; if (mul_i_rdy !== 1'b1) begin n_fail++; $display("FAIL rbp_tag0_rdy: got %b want 1", mul_i_rdy); end
    tick();
    mul_i_val = 1'b0;
    n_checks++; if (res_val !== 4'b0001 || res_dat[0] !== D'(9) || res_ctl[0] !== 16'h0022) begin n_fail++; $display("FAIL rbp_tag0_res: got val=%b dat=%0d ctl=%h want val=0001 dat=9 ctl=0022", res_val, res_dat[0], res_ctl[0]); end
    x_res_rdy = '0;
    x_mul_i_val = 1'b1; x_mul_i_dat = 16'h1234; x_mul_i_ctl = 16'hC005;
    #1;
    n_checks++; if (x_mul_i_rdy !== 1'b1) begin n_fail++; $display("FAIL tag3_rdy: got %b want 1", x_mul_i_rdy); end
    tick();
    x_mul_i_val = 1'b0;
    n_checks++; if (x_tag_err !== 1'b1 || x_res_val !== 3'b000) begin n_fail++; $display("FAIL tag3_drop: got err=%b val=%b want err=1 val=000", x_tag_err, x_res_val); end
    tick();
    n_checks++; if (x_tag_err !== 1'b0) begin n_fail++; $display("FAIL tag3_pulse: got %b want 0", x_tag_err); end
    x_mul_i_val = 1'b1; x_mul_i_ctl = 16'h8005;
    tick();
    n_checks++; if (x_res_val !== 3'b100 || x_res_ctl[2] !== 16'h0005 || x_res_dat[2] !== 16'h1234 || x_tag_err !== 1'b0) begin n_fail++; $display("FAIL tag2_route: got val=%b ctl=%h dat=%h err=%b want val=100 ctl=0005 dat=1234 err=0", x_res_val, x_res_ctl[2], x_res_dat[2], x_tag_err); end
    #1;
    n_checks++; if (x_mul_i_rdy !== 1'b0) begin n_fail++; $display("FAIL tag2_full_rdy: got %b want 0", x_mul_i_rdy); end
    idle();
  endtask

  task automatic test_back_to_back();
    int sent[N];
    int got[N];
    logic [D-1:0] pq[$];
    logic [C-1:0] cq[$];
    logic [N-1:0] acc_req;
    logic mo, mi, done;
    logic [2*D-1:0] mo_dat;
    logic [C-1:0] mo_ctl;
    logic [D-1:0] ep;
    int cyc;
    idle();
    rst_pulse();
    for (int k = 0; k < N; k++) begin sent[k] = 0; got[k] = 0; end
    cyc = 0; done = 1'b0;
    while (!done && cyc < 600) begin
      for (int k = 0; k < N; k++) begin
        if (sent[k] < NP && ((cyc + k) % 7) != 3) begin
          req_val[k] = 1'b1;
          req_dat[k] = {eb(k, sent[k]), ea(k, sent[k])};
          req_ctl[k] = {2'b11, 14'(k * 100 + sent[k])};
        end else begin
          req_val[k] = 1'b0;
        end
        res_rdy[k] = ((cyc + k) % 5) != 0;
      end
      mul_o_rdy = (cyc % 3) != 2;
      if (pq.size() > 0 && (cyc % 4) != 1) begin
        mul_i_val = 1'b1; mul_i_dat = pq[0]; mul_i_ctl = cq[0];
      end else begin
        mul_i_val = 1'b0;
      end
      #1;
      acc_req = req_val & req_rdy;
      mo = mul_o_val && mul_o_rdy; mo_dat = mul_o_dat; mo_ctl = mul_o_ctl;
      mi = mul_i_val && mul_i_rdy;
      for (int k = 0; k < N; k++) begin
        if (res_val[k] && res_rdy[k]) begin
          ep = ea(k, got[k]) * eb(k, got[k]);
          n_checks++; if (res_dat[k] !== ep || res_ctl[k] !== {2'b00, 14'(k * 100 + got[k])} || res_err[k] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ch%0d_beat%0d: got dat=%0d ctl=%h err=%b want dat=%0d ctl=%h err=0", k, got[k], res_dat[k], res_ctl[k], res_err[k], ep, {2'b00, 14'(k * 100 + got[k])});
          end
          got[k]++;
        end
      end
      tick();
      for (int k = 0; k < N; k++) if (acc_req[k]) sent[k]++;
      if (mi) begin void'(pq.pop_front()); void'(cq.pop_front()); end
      if (mo) begin pq.push_back(mo_dat[D-1:0] * mo_dat[2*D-1:D]); cq.push_back(mo_ctl); end
      cyc++;
      done = 1'b1;
      for (int k = 0; k < N; k++) if (got[k] != NP) done = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      n_checks++; if (got[k] !== NP) begin n_fail++; $display("FAIL b2b_count_ch%0d: got %0d results want %0d", k, got[k], NP); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    rst_pulse();
    mul_o_rdy = 1'b0; res_rdy = '0;
    req_val[2] = 1'b1; req_dat[2] = {D'(2), D'(1)};
    tick();
    req_val = '0;
    mul_i_val = 1'b1; mul_i_dat = D'(5); mul_i_ctl = 16'h4001;
    tick();
    mul_i_dat = D'(6); mul_i_ctl = 16'h8002;
    tick();
    mul_i_val = 1'b0;
    n_checks++; if (mul_o_val !== 1'b1 || res_val !== 4'b0110) begin n_fail++; $display("FAIL rmid_pre: got mul_val=%b res_val=%b want 1/0110", mul_o_val, res_val); end
    rst = 1'b0; req_val = '1; mul_o_rdy = 1'b1; mul_i_val = 1'b1; mul_i_ctl = 16'h0000;
    #1;
    n_checks++; if (req_rdy !== 4'b0000 || mul_i_rdy !== 1'b0) begin n_fail++; $display("FAIL rmid_rdy_forced: got req=%b mul_i=%b want 0000/0", req_rdy, mul_i_rdy); end
    tick();
    rst = 1'b1; mul_i_val = 1'b0;
    n_checks++; if (mul_o_val !== 1'b0 || res_val !== 4'b0000 || tag_err !== 1'b0) begin n_fail++; $display("FAIL rmid_cleared: got mul_val=%b res_val=%b tag_err=%b want 0/0000/0", mul_o_val, res_val, tag_err); end
    n_checks++; if (mul_o_ctl !== 16'h0000 || res_dat[1] !== D'(0)) begin n_fail++; $display("FAIL rmid_data: got ctl=%h res1=%0d want 0000/0", mul_o_ctl, res_dat[1]); end
    #1;
    n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_grant: got %b want 0001", req_rdy); end
    tick();
    n_checks++; if (mul_o_val !== 1'b1 || mul_o_ctl[15:14] !== 2'd0) begin n_fail++; $display("FAIL rmid_first_beat: got val=%b tag=%0d want 1/0", mul_o_val, mul_o_ctl[15:14]); end
    idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_issue_backpressure();
    test_result_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
